wshb_arbiter_rr: RTL and testbench

WSHB_ARBITER_RR -- requirements
Module: wshb_arbiter_rr

---
 rtl/wshb_arbiter_rr_if.sv | 27 ++
 rtl/wshb_arbiter_rr.sv | 159 +++++++++++++++
 tb/tb_wshb_arbiter_rr.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wshb_arbiter_rr_if.sv
// Wishbone B4 bundle shared by the arbiter's two requesters and its SDRAM-side port.
//   master modport : drives cyc/stb/adr/we/sel/cti/bte/dat_ms, receives dat_sm/ack/err/rty
//   slave  modport : the mirror image
interface wshb_if;
    logic        cyc;
    logic        stb;
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output cyc, stb, adr, we, sel, cti, bte, dat_ms,
        input  dat_sm, ack, err, rty
    );

    modport slave (
        input  cyc, stb, adr, we, sel, cti, bte, dat_ms,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/wshb_arbiter_rr.sv
// Two-master round-robin Wishbone arbiter in front of the SDRAM controller.
// Ownership is held for a whole cyc and is only taken away at an ack boundary
// once MAX_GRANT acks have been served and the other master is waiting.
//   clk        : Wishbone system clock
//   rst        : synchronous, active-high reset
//   wshb_ifs_0 : requester 0 (video reader)
//   wshb_ifs_1 : requester 1 (frame writer / test-pattern generator)
//   wshb_ifm   : shared path to the SDRAM controller
//   grant      : registered one-hot owner {OWN1, OWN0}, 2'b00 when nobody owns the bus
module wshb_arbiter_rr #(
    parameter int MAX_GRANT    = 64,
    parameter int FIRST_MASTER = 0
) (
    input  logic       clk,
    input  logic       rst,
    wshb_if.slave      wshb_ifs_0,
    wshb_if.slave      wshb_ifs_1,
    wshb_if.master     wshb_ifm,
    output logic [1:0] grant
);

    localparam int             CW       = $clog2(MAX_GRANT + 1);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(MAX_GRANT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(MAX_GRANT - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
    // Pretending the other master went last makes FIRST_MASTER win the first tie.
    localparam logic           LAST_RST = (FIRST_MASTER == 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        IDLE,
        OWN0,
        OWN1,
        GAP
    } state_t;

    state_t         state, state_nxt;
    logic           last_owner, last_owner_nxt;
    logic [CW-1:0]  ack_cnt, ack_cnt_nxt;
    logic           req0, req1;
    logic           quota_hit;

    assign req0 = wshb_ifs_0.cyc;
    assign req1 = wshb_ifs_1.cyc;

    // The ack arriving now is the one that uses up the owner's quota
    // (or the quota is already saturated).
    assign quota_hit = wshb_ifm.ack && (ack_cnt >= CNT_LAST);

    // NOTE: every signal written in a combinational block gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        ack_cnt_nxt    = ack_cnt;
        unique case (state)
            IDLE: begin
                ack_cnt_nxt = '0;
                if (req0 && req1) begin
                    state_nxt = last_owner ? OWN0 : OWN1;
                end else if (req0) begin
                    state_nxt = OWN0;
                end else if (req1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (wshb_ifm.ack && (ack_cnt != CNT_MAX)) begin
                    ack_cnt_nxt = ack_cnt + CNT_ONE;
                end
                // Preemption only ever happens on an ack, never mid-transfer.
                if ((quota_hit && req1) || (!req0 && !wshb_ifm.ack)) begin
                    state_nxt      = GAP;
                    last_owner_nxt = 1'b0;
                end
            end
            OWN1: begin
                if (wshb_ifm.ack && (ack_cnt != CNT_MAX)) begin
                    ack_cnt_nxt = ack_cnt + CNT_ONE;
                end
                if ((quota_hit && req0) || (!req1 && !wshb_ifm.ack)) begin
                    state_nxt      = GAP;
                    last_owner_nxt = 1'b1;
                end
            end
            GAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= LAST_RST;
            ack_cnt    <= '0;
            grant      <= 2'b00;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
            ack_cnt    <= ack_cnt_nxt;
            grant      <= {state_nxt == OWN1, state_nxt == OWN0};
        end
    end

    // Request path is a pure function of the registered state and the owner's
    // signals, so wshb_ifm.ack never loops back into cyc/stb.
    always_comb begin
        wshb_ifm.cyc    = 1'b0;
        wshb_ifm.stb    = 1'b0;
        wshb_ifm.adr    = '0;
        wshb_ifm.we     = 1'b0;
        wshb_ifm.sel    = '0;
        wshb_ifm.cti    = '0;
        wshb_ifm.bte    = '0;
        wshb_ifm.dat_ms = '0;
        wshb_ifs_0.ack  = 1'b0;
        wshb_ifs_1.ack  = 1'b0;
        unique case (state)
            OWN0: begin
                wshb_ifm.cyc    = wshb_ifs_0.cyc;
                wshb_ifm.stb    = wshb_ifs_0.stb;
                wshb_ifm.adr    = wshb_ifs_0.adr;
                wshb_ifm.we     = wshb_ifs_0.we;
                wshb_ifm.sel    = wshb_ifs_0.sel;
                wshb_ifm.cti    = wshb_ifs_0.cti;
                wshb_ifm.bte    = wshb_ifs_0.bte;
                wshb_ifm.dat_ms = wshb_ifs_0.dat_ms;
                wshb_ifs_0.ack  = wshb_ifm.ack;
            end
            OWN1: begin
                wshb_ifm.cyc    = wshb_ifs_1.cyc;
                wshb_ifm.stb    = wshb_ifs_1.stb;
                wshb_ifm.adr    = wshb_ifs_1.adr;
                wshb_ifm.we     = wshb_ifs_1.we;
                wshb_ifm.sel    = wshb_ifs_1.sel;
                wshb_ifm.cti    = wshb_ifs_1.cti;
                wshb_ifm.bte    = wshb_ifs_1.bte;
                wshb_ifm.dat_ms = wshb_ifs_1.dat_ms;
                wshb_ifs_1.ack  = wshb_ifm.ack;
            end
            default: begin
            end
        endcase
    end

    // Read data is broadcast; only the ack tells a master the data is for it.
    assign wshb_ifs_0.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs_1.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs_0.err    = 1'b0;
    assign wshb_ifs_0.rty    = 1'b0;
    assign wshb_ifs_1.err    = 1'b0;
    assign wshb_ifs_1.rty    = 1'b0;

endmodule

// File: tb/tb_wshb_arbiter_rr.sv
// Bench for wshb_arbiter_rr: two master BFMs, an SDRAM responder with
// programmable wait states, a bus-ownership reference model and a scoreboard.
module tb_wshb_arbiter_rr;

    localparam int MAX_GRANT    = 4;
    localparam int FIRST_MASTER = 0;

    typedef struct packed {
        logic [31:0] adr;
        logic        we;
        logic [3:0]  sel;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic [31:0] dat;
    } xfer_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] grant;

    wshb_if m0 ();
    wshb_if m1 ();
    wshb_if sd ();

    wshb_arbiter_rr #(
        .MAX_GRANT    (MAX_GRANT),
        .FIRST_MASTER (FIRST_MASTER)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wshb_ifs_0 (m0),
        .wshb_ifs_1 (m1),
        .wshb_ifm   (sd),
        .grant      (grant)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, wanted 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Sequencer knobs, sampled by the driver one step after each rising edge.
    bit    rst_k = 1'b1;
    bit    en_k[2];
    int    budget[2];
    int    ws_k = 0;
    bit    fix_v[2];
    xfer_t fix_x[2];

    // Master BFM state and per-master scoreboard of the transfer on offer.
    bit    pend[2];
    bit    cyc_d[2];
    xfer_t cur[2];
    xfer_t sq[2][$];
    int    exp_q[$];
    int    wcnt = 0;

    // Ownership model: owner -1 means nobody; cool counts the forced
    // dead cycle that follows every release before arbitration resumes.
    int m_owner = -1;
    int m_cool  = 0;
    int m_last  = 1 - FIRST_MASTER;
    int m_cnt   = 0;

    task automatic model_step(input bit c0, input bit c1, input bit ack, input bit r);
        bit c[2];
        int o;
        c[0] = c0;
        c[1] = c1;
        if (r) begin
            m_owner = -1;
            m_cool  = 0;
            m_last  = 1 - FIRST_MASTER;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            if (m_cool > 0) begin
                m_cool--;
            end else if (c[0] || c[1]) begin
                m_owner = (c[0] && c[1]) ? 1 - m_last : (c[0] ? 0 : 1);
                m_cnt   = 0;
            end
        end else begin
            o = m_owner;
            if (ack) m_cnt = (m_cnt + 1 > MAX_GRANT) ? MAX_GRANT : m_cnt + 1;
            if ((ack && m_cnt == MAX_GRANT && c[1-o]) || (!c[o] && !ack)) begin
                m_last  = o;
                m_owner = -1;
                m_cool  = 1;
            end
        end
    endtask

    task automatic bfm_step(input int i, input bit acked);
        bit cyc_new;
        xfer_t x;
        if (acked && pend[i]) begin
            pend[i] = 1'b0;
            if (budget[i] > 0) budget[i]--;
        end
        cyc_new = en_k[i] && (budget[i] != 0);
        if (pend[i] && !cyc_new) begin
            pend[i] = 1'b0;
            if (sq[i].size() > 0) void'(sq[i].pop_back());
        end
        if (cyc_new && !pend[i]) begin
            if (fix_v[i]) begin
                x = fix_x[i];
                fix_v[i] = 1'b0;
            end else begin
                x.adr = $urandom;
                x.we  = 1'($urandom_range(0, 1));
                x.sel = 4'($urandom_range(0, 15));
                x.cti = 3'($urandom_range(0, 7));
                x.bte = 2'($urandom_range(0, 3));
                x.dat = $urandom;
            end
            cur[i] = x;
            sq[i].push_back(x);
            pend[i] = 1'b1;
        end
        cyc_d[i] = cyc_new;
    endtask

    // NOTE: the bench drives DUT inputs with blocking assignments a step after
    // the rising edge, so the DUT always samples settled values.
    initial begin : driver
        bit ack_s[2];
        bit stb_s;
        m0.cyc = 1'b0; m0.stb = 1'b0;
        {m0.adr, m0.we, m0.sel, m0.cti, m0.bte, m0.dat_ms} = '0;
        m1.cyc = 1'b0; m1.stb = 1'b0;
        {m1.adr, m1.we, m1.sel, m1.cti, m1.bte, m1.dat_ms} = '0;
        sd.ack = 1'b0; sd.err = 1'b0; sd.rty = 1'b0; sd.dat_sm = '0;
        budget[0] = -1;
        budget[1] = -1;
        forever begin
            @(negedge clk);
            ack_s[0] = m0.ack;
            ack_s[1] = m1.ack;
            stb_s    = sd.cyc && sd.stb;
            @(posedge clk);
            #1;
            model_step(cyc_d[0], cyc_d[1], sd.ack, rst);
            exp_q.push_back(m_owner);
            if (rst || !stb_s || sd.ack) wcnt = ws_k;
            else if (wcnt > 0) wcnt--;
            for (int i = 0; i < 2; i++) bfm_step(i, ack_s[i]);
            rst = rst_k;
            m0.cyc = cyc_d[0]; m0.stb = cyc_d[0];
            {m0.adr, m0.we, m0.sel, m0.cti, m0.bte, m0.dat_ms} = cyc_d[0] ? cur[0] : '0;
            m1.cyc = cyc_d[1]; m1.stb = cyc_d[1];
            {m1.adr, m1.we, m1.sel, m1.cti, m1.bte, m1.dat_ms} = cyc_d[1] ? cur[1] : '0;
            #1;
            sd.ack    = sd.cyc && sd.stb && (wcnt == 0);
            sd.dat_sm = $urandom;
        end
    end

    initial begin : monitor
        int    o;
        bit    ecyc;
        xfer_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) continue;
            o    = exp_q.pop_front();
            ecyc = (o >= 0) ? cyc_d[o] : 1'b0;
            check("grant", grant, (o < 0) ? 2'b00 : ((o == 0) ? 2'b01 : 2'b10));
            check("ifm_cyc", sd.cyc, ecyc);
            check("ifm_stb", sd.stb, ecyc);
            check("ack0", m0.ack, (o == 0) && sd.ack);
            check("ack1", m1.ack, (o == 1) && sd.ack);
            check("err_rty", {m0.err, m0.rty, m1.err, m1.rty}, 4'b0000);
            check("dat_sm0", m0.dat_sm, sd.dat_sm);
            check("dat_sm1", m1.dat_sm, sd.dat_sm);
            if (ecyc) begin
                if (sq[o].size() == 0) begin
                    check("sb_underflow", sq[o].size(), 1);
                end else begin
                    x = sq[o][0];
                    check("ifm_xfer", {sd.adr, sd.we, sd.sel, sd.cti, sd.bte, sd.dat_ms}, x);
                    if (sd.ack) void'(sq[o].pop_front());
                end
            end else begin
                check("ifm_quiet", {sd.adr, sd.we, sd.sel, sd.cti, sd.bte, sd.dat_ms}, '0);
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset(input int n);
        rst_k = 1'b1;
        cycles(n);
        rst_k = 1'b0;
    endtask

    initial begin : sequencer
        bit reached;
        @(posedge clk);

        // Reader alone, SDRAM acking every cycle.
        en_k[0] = 1'b1; en_k[1] = 1'b0;
        do_reset(2);
        cycles(20);

        // Both from reset: alternating bursts of MAX_GRANT acks.
        en_k[1] = 1'b1;
        do_reset(2);
        cycles(40);

        // Reader releases after 3 acks, writer arrives later.
        en_k[0] = 1'b0; en_k[1] = 1'b0;
        do_reset(2);
        budget[0] = 3; en_k[0] = 1'b1;
        cycles(15);
        en_k[1] = 1'b1;
        cycles(12);

        // Slow SDRAM: writer requests in the middle of a wait.
        en_k[0] = 1'b0; en_k[1] = 1'b0;
        budget[0] = -1; budget[1] = -1;
        ws_k = 5;
        do_reset(2);
        en_k[0] = 1'b1;
        cycles(9);
        en_k[1] = 1'b1;
        cycles(70);

        // Reset pulse while the writer owns the bus.
        ws_k = 0;
        do_reset(2);
        reached = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (grant === 2'b10) begin
                reached = 1'b1;
                break;
            end
        end
        check("writer_owns_before_reset", reached, 1'b1);
        @(posedge clk);
        rst_k = 1'b1;
        @(posedge clk);
        rst_k = 1'b0;
        cycles(20);

        // Directed write from the writer.
        en_k[0] = 1'b0; en_k[1] = 1'b0;
        do_reset(2);
        fix_x[1].adr = 32'h0000_0100;
        fix_x[1].we  = 1'b1;
        fix_x[1].sel = 4'b0110;
        fix_x[1].cti = 3'd0;
        fix_x[1].bte = 2'd0;
        fix_x[1].dat = 32'hC01D_CAFE;
        fix_v[1]  = 1'b1;
        budget[1] = 1;
        en_k[1]   = 1'b1;
        cycles(10);

        // Random traffic: request toggling, wait-state changes, stray resets.
        budget[0] = -1; budget[1] = -1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            if ($urandom_range(0, 39) == 0) en_k[0] = ~en_k[0];
            if ($urandom_range(0, 14) == 0) en_k[1] = ~en_k[1];
            if ($urandom_range(0, 99) == 0) ws_k = $urandom_range(0, 3);
            rst_k = ($urandom_range(0, 299) == 0);
        end
        rst_k = 1'b0;
        cycles(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
